// File: rtl/ether_phy_mgr_pkg.sv
// Shared definitions for the PHY command sequencer: controller command
// codes, status-word bit positions and the common counter width.
package ether_phy_mgr_pkg;

   typedef enum logic [3:0] {
      ECTL_CMD_NOP     = 4'd0,
      ECTL_CMD_RESET   = 4'd1,
      ECTL_CMD_SETMODE = 4'd2,
      ECTL_CMD_GETSTAT = 4'd3
   } ectl_cmd_e;

   localparam int unsigned PHY_STAT_LINK_BIT = 2;
   localparam int unsigned PHY_STAT_W        = 16;
   localparam int unsigned CNT_W             = 32;

endpackage

// File: rtl/ether_phy_mgr_if.sv
// Command port between the sequencer (master) and the MDIO PHY controller
// (slave). ready is a completion toggle from the MDC domain; rdata is held
// stable by the controller until the next GETSTAT.
interface ether_phy_mgr_if;

   logic        cs;
   logic [3:0]  cmd;
   logic        ready;
   logic [15:0] rdata;

   modport master (output cs, output cmd, input ready, input rdata);
   modport slave  (input cs, input cmd, output ready, output rdata);

endinterface

// File: rtl/ether_phy_mgr_toggle_sync.sv
// Brings an asynchronous completion toggle into the clk domain and turns
// every change of level into a one-clk pulse. Usable for any MDC->clk toggle.
module ether_phy_mgr_toggle_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic tog_in,
   output logic pulse
);

   logic s1_r;
   logic s2_r;
   logic s3_r;

   // Two-flop synchroniser followed by a history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= tog_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   assign pulse = s2_r ^ s3_r;

endmodule

// File: rtl/ether_phy_mgr.sv
// PHY management sequencer: RESET, recovery wait, SETMODE, then periodic
// GETSTAT polling. Publishes the status word and link state and flags a
// controller that stops answering.
module ether_phy_mgr
   import ether_phy_mgr_pkg::*;
#(
   parameter int unsigned RESET_WAIT_CYC = 50000,
   parameter int unsigned POLL_CYC       = 5000000,
   parameter int unsigned TIMEOUT_CYC    = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  restart,
   ether_phy_mgr_if.master       ectl,
   output logic [PHY_STAT_W-1:0] phy_stat,
   output logic                  link_up,
   output logic                  link_change,
   output logic                  mgr_err
);

   typedef enum logic [2:0] {
      S_INIT      = 3'd0,
      S_RST_WAIT  = 3'd1,
      S_HOLD      = 3'd2,
      S_MODE_WAIT = 3'd3,
      S_POLL_WAIT = 3'd4,
      S_CAPT      = 3'd5,
      S_IDLE      = 3'd6,
      S_FAIL      = 3'd7
   } state_e;

   localparam logic [CNT_W-1:0] INIT_LAST = 32'd3;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

   state_e           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             cs_r;
   ectl_cmd_e        cmd_r;
   logic             done_s;

   ether_phy_mgr_toggle_sync u_ready_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .tog_in (ectl.ready),
      .pulse  (done_s)
   );

   assign ectl.cs  = cs_r;
   assign ectl.cmd = cmd_r;

   // Sequencer FSM with the shared wait/timeout counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_INIT;
         cnt_r       <= 32'd0;
         cs_r        <= 1'b0;
         cmd_r       <= ECTL_CMD_NOP;
         phy_stat    <= 16'h0000;
         link_up     <= 1'b0;
         link_change <= 1'b0;
         mgr_err     <= 1'b0;
      end else if (restart) begin
         // Abort everything; the status word and link state stay visible.
         state_r     <= S_INIT;
         cnt_r       <= 32'd0;
         cs_r        <= 1'b0;
         cmd_r       <= ECTL_CMD_NOP;
         link_change <= 1'b0;
         mgr_err     <= 1'b0;
      end else begin
         link_change <= 1'b0;
         case (state_r)
            S_INIT: begin
               // Gives the synchroniser time to flush a power-up or stale toggle.
               if (cnt_r == INIT_LAST) begin
                  state_r <= S_RST_WAIT;
                  cnt_r   <= 32'd0;
                  cs_r    <= 1'b1;
                  cmd_r   <= ECTL_CMD_RESET;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            S_RST_WAIT, S_MODE_WAIT, S_POLL_WAIT: begin
               if (done_s) begin
                  cs_r  <= 1'b0;
                  cmd_r <= ECTL_CMD_NOP;
                  if (state_r == S_RST_WAIT) begin
                     state_r <= S_HOLD;
                     cnt_r   <= 32'd0;
                  end else if (state_r == S_MODE_WAIT) begin
                     // Park in IDLE with the poll interval already expired so the
                     // first GETSTAT goes out after exactly one clk with cs low.
                     state_r <= S_IDLE;
                     cnt_r   <= POLL_LAST;
                  end else begin
                     state_r <= S_CAPT;
                     cnt_r   <= 32'd0;
                  end
               end else if (cnt_r == TO_LAST) begin
                  state_r <= S_FAIL;
                  cnt_r   <= 32'd0;
                  cs_r    <= 1'b0;
                  cmd_r   <= ECTL_CMD_NOP;
                  mgr_err <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            S_HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  state_r <= S_MODE_WAIT;
                  cnt_r   <= 32'd0;
                  cs_r    <= 1'b1;
                  cmd_r   <= ECTL_CMD_SETMODE;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            S_CAPT: begin
               // rdata has been stable for several clk by now.
               phy_stat    <= ectl.rdata;
               link_up     <= ectl.rdata[PHY_STAT_LINK_BIT];
               link_change <= (ectl.rdata[PHY_STAT_LINK_BIT] != link_up);
               state_r     <= S_IDLE;
               cnt_r       <= 32'd0;
            end
            S_IDLE: begin
               if (cnt_r == POLL_LAST) begin
                  state_r <= S_POLL_WAIT;
                  cnt_r   <= 32'd0;
                  cs_r    <= 1'b1;
                  cmd_r   <= ECTL_CMD_GETSTAT;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            S_FAIL: begin
               cs_r  <= 1'b0;
               cmd_r <= ECTL_CMD_NOP;
            end
            default: begin
               state_r <= S_INIT;
               cnt_r   <= 32'd0;
               cs_r    <= 1'b0;
               cmd_r   <= ECTL_CMD_NOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ether_phy_mgr.sv
// Bench for ether_phy_mgr: a behavioural PHY-controller model answers
// requests, a per-cycle checker enforces the output rules, and a directed
// sequence pins timing and status values with hand-computed literals.
module tb_ether_phy_mgr;

   logic        clk;
   logic        rst_n;
   logic        restart;
   logic [15:0] phy_stat;
   logic        link_up;
   logic        link_change;
   logic        mgr_err;

   int n_tests = 0;
   int n_fail  = 0;

   // PHY controller model knobs and bookkeeping
   logic        resp_en   = 1'b1;
   int          resp_dly  = 8;
   int          stale_req = 0;
   int          stale_done = 0;
   logic [15:0] stat_q[$];
   logic [3:0]  exp_cmd   = 4'd1;
   time         tog_time  = 0;
   int          lc_pulses = 0;

   ether_phy_mgr_if ectl ();

   ether_phy_mgr #(
      .RESET_WAIT_CYC (100),
      .POLL_CYC       (200),
      .TIMEOUT_CYC    (1000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .restart     (restart),
      .ectl        (ectl),
      .phy_stat    (phy_stat),
      .link_up     (link_up),
      .link_change (link_change),
      .mgr_err     (mgr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endfunction

   // PHY controller model: answers each request after resp_dly clk with a
   // ready toggle; GETSTAT answers carry the next queued status word.
   initial begin : phy_model
      logic       prev_cs;
      logic       pend;
      int         cd;
      logic [3:0] cur_cmd;
      prev_cs = 1'b0;
      pend    = 1'b0;
      cd      = 0;
      cur_cmd = 4'd0;
      ectl.ready = 1'b0;
      ectl.rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (stale_req != stale_done) begin
            stale_done = stale_req;
            ectl.rdata = 16'hDEAD;
            ectl.ready = ~ectl.ready;
         end
         if (!rst_n || restart) begin
            exp_cmd = 4'd1;
            pend    = 1'b0;
            prev_cs = 1'b0;
         end else begin
            if (ectl.cs && !prev_cs) begin
               chk("req_cmd_order", {28'd0, ectl.cmd}, {28'd0, exp_cmd});
               pend    = 1'b1;
               cd      = resp_dly;
               cur_cmd = ectl.cmd;
            end
            if (pend && !ectl.cs) begin
               pend = 1'b0;
            end else if (pend && resp_en) begin
               cd--;
               if (cd <= 0) begin
                  if (cur_cmd == 4'd3 && stat_q.size() > 0) ectl.rdata = stat_q.pop_front();
                  ectl.ready = ~ectl.ready;
                  tog_time   = $time;
                  pend       = 1'b0;
                  exp_cmd    = (cur_cmd == 4'd1) ? 4'd2 : 4'd3;
               end
            end
            prev_cs = ectl.cs;
         end
      end
   end

   // Per-cycle output rules: reset values, link_up tracks bit 2, link_change
   // marks exactly the cycles where link_up changed, legal command encoding.
   initial begin : compare
      logic have_prev;
      logic prev_lu;
      have_prev = 1'b0;
      prev_lu   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_cs", {31'd0, ectl.cs}, 32'd0);
            chk("rst_cmd", {28'd0, ectl.cmd}, 32'd0);
            chk("rst_phy_stat", {16'd0, phy_stat}, 32'd0);
            chk("rst_link", {30'd0, link_up, link_change}, 32'd0);
            chk("rst_err", {31'd0, mgr_err}, 32'd0);
            have_prev = 1'b0;
         end else begin
            chk("link_bit", {31'd0, link_up}, {31'd0, phy_stat[2]});
            if (have_prev) chk("link_change", {31'd0, link_change}, {31'd0, link_up != prev_lu});
            if (link_change) lc_pulses++;
            if (ectl.cs) chk_rng("cmd_active", int'(ectl.cmd), 1, 3);
            else         chk("cmd_idle", {28'd0, ectl.cmd}, 32'd0);
            if (mgr_err) chk("err_quiet", {31'd0, ectl.cs}, 32'd0);
            prev_lu   = link_up;
            have_prev = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drv();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_cs(input logic lvl, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (ectl.cs === lvl) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic settle3();
      repeat (3) @(negedge clk);
   endtask

   initial begin : stim
      int n;
      int lc0;
      rst_n   = 1'b1;
      restart = 1'b0;
      #1 rst_n = 1'b0;
      stat_q.push_back(16'h782D);
      stat_q.push_back(16'h7809);
      stat_q.push_back(16'h7809);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_phy_stat", {16'd0, phy_stat}, 32'h0);
      drv();
      rst_n = 1'b1;

      // Power-up: RESET request, then drop within 4 clk of the toggle
      wait_cs(1'b1, 6, n);
      chk_rng("pwr_cs_rise", n, 1, 6);
      chk("pwr_cmd", {28'd0, ectl.cmd}, 32'd1);
      wait_cs(1'b0, 20, n);
      chk_rng("rst_done_lat", int'(($time - tog_time) / 10), 2, 4);

      // SETMODE after the recovery hold, GETSTAT right after SETMODE
      wait_cs(1'b1, 120, n);
      chk_rng("hold_len", n, 96, 104);
      chk("mode_cmd", {28'd0, ectl.cmd}, 32'd2);
      wait_cs(1'b0, 20, n);
      wait_cs(1'b1, 4, n);
      chk_rng("getstat_gap", n, 1, 2);
      chk("getstat_cmd", {28'd0, ectl.cmd}, 32'd3);

      // Poll 1: 0x782D -> link up, one pulse
      lc0 = lc_pulses;
      wait_cs(1'b0, 20, n);
      settle3();
      chk("poll1_stat", {16'd0, phy_stat}, 32'h782D);
      chk("poll1_link", {31'd0, link_up}, 32'd1);
      chk("poll1_pulse", lc_pulses - lc0, 32'd1);

      // Poll 2: 0x7809 -> link down, one pulse
      wait_cs(1'b1, 250, n);
      chk_rng("poll_period", n, 196, 200);
      lc0 = lc_pulses;
      wait_cs(1'b0, 20, n);
      settle3();
      chk("poll2_stat", {16'd0, phy_stat}, 32'h7809);
      chk("poll2_link", {31'd0, link_up}, 32'd0);
      chk("poll2_pulse", lc_pulses - lc0, 32'd1);

      // Poll 3: 0x7809 again -> no pulse
      wait_cs(1'b1, 250, n);
      lc0 = lc_pulses;
      wait_cs(1'b0, 20, n);
      settle3();
      chk("poll3_stat", {16'd0, phy_stat}, 32'h7809);
      chk("poll3_pulse", lc_pulses - lc0, 32'd0);

      // Restart mid-GETSTAT with a stale toggle carrying junk rdata
      drv();
      resp_dly = 60;
      wait_cs(1'b1, 250, n);
      repeat (5) @(negedge clk);
      chk("mid_cmd_cs", {31'd0, ectl.cs}, 32'd1);
      drv();
      restart = 1'b1;
      stale_req++;
      drv();
      restart  = 1'b0;
      resp_dly = 8;
      stat_q.push_back(16'h782D);
      @(negedge clk);
      chk("rs_cs_drop", {31'd0, ectl.cs}, 32'd0);
      chk("rs_err", {31'd0, mgr_err}, 32'd0);
      chk("rs_stat_kept", {16'd0, phy_stat}, 32'h7809);
      wait_cs(1'b1, 8, n);
      chk_rng("rs_rise", n, 1, 8);
      chk("rs_cmd", {28'd0, ectl.cmd}, 32'd1);
      wait_cs(1'b0, 20, n);
      wait_cs(1'b1, 120, n);
      chk("rs_mode_cmd", {28'd0, ectl.cmd}, 32'd2);
      wait_cs(1'b0, 20, n);
      wait_cs(1'b1, 4, n);
      chk("rs_get_cmd", {28'd0, ectl.cmd}, 32'd3);
      chk("stale_ignored", {16'd0, phy_stat}, 32'h7809);
      wait_cs(1'b0, 20, n);
      settle3();
      chk("rs_poll_stat", {16'd0, phy_stat}, 32'h782D);
      chk("rs_poll_link", {31'd0, link_up}, 32'd1);

      // Async reset during the recovery hold
      drv();
      restart = 1'b1;
      drv();
      restart = 1'b0;
      wait_cs(1'b1, 8, n);
      wait_cs(1'b0, 20, n);
      repeat (20) @(negedge clk);
      drv();
      rst_n = 1'b0;
      #1;
      chk("ar_stat", {16'd0, phy_stat}, 32'h0);
      chk("ar_link", {30'd0, link_up, link_change}, 32'd0);
      chk("ar_cs", {31'd0, ectl.cs}, 32'd0);
      drv();
      rst_n   = 1'b1;
      resp_en = 1'b0;
      wait_cs(1'b1, 8, n);
      chk_rng("ar_rerun", n, 1, 8);
      chk("ar_cmd", {28'd0, ectl.cmd}, 32'd1);

      // Timeout: controller never answers
      wait_cs(1'b0, 1100, n);
      chk_rng("to_len", n, 998, 1002);
      chk("to_err", {31'd0, mgr_err}, 32'd1);
      wait_cs(1'b1, 5000, n);
      chk("to_quiet", n, 32'hFFFF_FFFF);
      chk("to_err_sticky", {31'd0, mgr_err}, 32'd1);
      drv();
      resp_en = 1'b1;
      restart = 1'b1;
      drv();
      restart = 1'b0;
      @(negedge clk);
      chk("to_err_clear", {31'd0, mgr_err}, 32'd0);
      wait_cs(1'b1, 8, n);
      chk("to_rerun_cmd", {28'd0, ectl.cmd}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
